// File: rtl/fir_mac_sequencer_if.sv
// Sample/result/coefficient bundle for fir_mac_sequencer.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds its data and valid stable until that edge, and ready may not
// depend combinationally on valid from the same side.
interface fir_mac_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 3,
  parameter int AW    = $clog2(TAPS),
  parameter int ACC_W = 2*WIDTH + $clog2(TAPS)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [WIDTH-1:0] coef_data;
  logic             coef_err;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] y_out;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output in_valid, x_in, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, coef_err, out_valid, y_out, busy, state
  );

  modport slave (
    input  in_valid, x_in, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, coef_err, out_valid, y_out, busy, state
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one signed MAC is stepped over TAPS taps per accepted sample.
// Optional macro FIR_COEF_LOCK_EN: coefficient writes only honoured while IDLE.
module fir_mac_sequencer #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 3,
  parameter int AW    = $clog2(TAPS),
  parameter int ACC_W = 2*WIDTH + $clog2(TAPS)
) (
  input logic                clk,
  input logic                rst,
  fir_mac_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t state, state_next;

  logic signed [WIDTH-1:0]   hist [TAPS];
  logic signed [WIDTH-1:0]   coef [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   y_reg;
  logic                      out_valid_reg;
  logic                      coef_err_reg;
  logic [AW-1:0]             wp;
  logic [AW-1:0]             base;
  logic [AW-1:0]             k;
  logic [AW-1:0]             rd_idx;
  logic                      in_ready_c;
  logic                      accept;
  logic                      addr_ok;
  logic                      coef_wr_ok;
  logic                      coef_drop;
  logic signed [2*WIDTH-1:0] h_ext;
  logic signed [2*WIDTH-1:0] x_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_sum;

  function automatic logic [WIDTH-1:0] default_coef(input int i);
    case (i)
      0:       return WIDTH'(1);
      1:       return WIDTH'(2);
      2:       return WIDTH'(1);
      default: return '0;
    endcase
  endfunction

  // (base - k) mod TAPS; the true result is below TAPS, so AW-bit wrap is harmless.
  always_comb begin
    rd_idx = base - k;
    if (base < k) rd_idx = base + AW'(TAPS) - k;
  end

  assign h_ext    = {{WIDTH{coef[k][WIDTH-1]}}, coef[k]};
  assign x_ext    = {{WIDTH{hist[rd_idx][WIDTH-1]}}, hist[rd_idx]};
  assign prod     = h_ext * x_ext;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc_sum  = acc + prod_ext;

  assign addr_ok = (int'(bus.coef_addr) < TAPS);
`ifdef FIR_COEF_LOCK_EN
  assign coef_wr_ok = bus.coef_we && addr_ok && (state == S_IDLE);
  assign coef_drop  = bus.coef_we && addr_ok && (state != S_IDLE);
`else
  assign coef_wr_ok = bus.coef_we && addr_ok;
  assign coef_drop  = 1'b0;
`endif

  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = S_MAC;
      end
      S_MAC:   if (k == LAST) state_next = S_OUT;
      S_OUT:   if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = in_ready_c && bus.in_valid;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= default_coef(i);
      end
      acc           <= '0;
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
      coef_err_reg  <= 1'b0;
      wp            <= '0;
      base          <= '0;
      k             <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            hist[wp] <= bus.x_in;
            base     <= wp;
            wp       <= (wp == LAST) ? '0 : wp + 1'b1;
            acc      <= '0;
            k        <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (k == LAST) begin
            y_reg         <= acc_sum;
            out_valid_reg <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_OUT:   if (bus.out_ready) out_valid_reg <= 1'b0;
        default: ;
      endcase
      // Lands at this edge, so a MAC step reading the same tap this cycle sees the old value.
      if (coef_wr_ok) coef[bus.coef_addr] <= bus.coef_data;
      coef_err_reg <= coef_drop;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.y_out     = y_reg;
  assign bus.coef_err  = coef_err_reg;
  assign bus.busy      = (state != S_IDLE);
  assign bus.state     = state;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed steps then random samples,
// compared against a queue-based convolution model.
module tb_fir_mac_sequencer;
  localparam int WIDTH = 8;
  localparam int TAPS  = 3;
  localparam int AW    = 2;
  localparam int ACC_W = 18;
`ifdef FIR_COEF_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.WIDTH(WIDTH), .TAPS(TAPS), .AW(AW), .ACC_W(ACC_W)) bus ();

  fir_mac_sequencer #(.WIDTH(WIDTH), .TAPS(TAPS), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: newest sample at the front of hist_q, signed coefficients as ints.
  int               hist_q[$];
  int               coef_m[TAPS];
  logic [ACC_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist_q.delete();
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
    coef_m[0] = 1;
    coef_m[1] = 2;
    coef_m[2] = 1;
  endfunction

  function automatic void model_accept(input int x);
    int sum;
    hist_q.push_front(x);
    if (hist_q.size() > TAPS) void'(hist_q.pop_back());
    sum = 0;
    for (int i = 0; i < TAPS; i++)
      if (i < hist_q.size()) sum += coef_m[i] * hist_q[i];
    exp_q.push_back(ACC_W'(sum));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_y_out", bus.y_out, 0);
    check("rst_coef_err", bus.coef_err, 0);
    rst = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr[AW-1:0];
    bus.coef_data = val[WIDTH-1:0];
    @(posedge clk);
    if (addr < TAPS) coef_m[addr] = val;
    @(negedge clk);
    bus.coef_we = 1'b0;
    check("coef_err_idle", bus.coef_err, 0);
  endtask

  // One sample end to end; hold = cycles the sink stalls; mac_wr writes h[0] during the first MAC cycle.
  task automatic run_sample(input int x, input int hold, input bit mac_wr, input int wr_val);
    int               lat;
    logic [ACC_W-1:0] exp_y;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.x_in      = x[WIDTH-1:0];
    bus.out_ready = (hold == 0);
    @(posedge clk);
    model_accept(x);
    exp_y = exp_q.pop_front();
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_mac", bus.busy, 1);
    check("in_ready_mac", bus.in_ready, 0);
    if (mac_wr) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = '0;
      bus.coef_data = wr_val[WIDTH-1:0];
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      if (mac_wr && lat == 1 && !LOCK) coef_m[0] = wr_val;
      @(negedge clk);
      if (mac_wr && lat == 1) begin
        bus.coef_we = 1'b0;
        check("coef_err_pulse", bus.coef_err, LOCK);
      end
      if (mac_wr && lat == 2) check("coef_err_clear", bus.coef_err, 0);
      if (bus.out_valid) break;
    end
    // out_valid registered TAPS edges after acceptance: the sink sees it at edge t+TAPS+1.
    check("out_latency", lat, TAPS);
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.x_in     = 8'h55;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_y_out", bus.y_out, exp_y);
        check("stall_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    check("y_out", bus.y_out, exp_y);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_clr", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Impulse then step response with default coefficients 1,2,1.
    do_reset();
    run_sample(1, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(10, 0, 0, 0);
    run_sample(10, 0, 0, 0);
    run_sample(10, 0, 0, 0);
    run_sample(10, 0, 0, 0);

    // Most negative input from clean history.
    do_reset();
    run_sample(-128, 0, 0, 0);
    run_sample(-128, 0, 0, 0);
    run_sample(-128, 5, 0, 0);

    // Programmed coefficient, ignored out-of-range write, write during MAC.
    do_reset();
    write_coef(1, -1);
    write_coef(3, 99);
    run_sample(1, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(1, 0, 1, 5);
    run_sample(0, 0, 0, 0);
    run_sample(0, 0, 0, 0);
    run_sample(1, 0, 0, 0);

    // Reset in the middle of MAC discards the result and history.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = 8'd33;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_before_rst", bus.busy, 1);
    do_reset();
    run_sample(7, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
      run_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
